// File: rtl/edge_mem_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// edge_mem_pkg
// Shared definitions for the edge-detector memory scheduler. It holds the
// scheduler FSM state encoding, the client index constants, the default bus
// widths and the width of the waitrequest watchdog counter.
// -----------------------------------------------------------------------------
package edge_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A client index also encodes the bus direction: client 0 only reads
    // (window fetch) and client 1 only writes (magnitude writeback).
    localparam logic CLIENT_RD = 1'b0;
    localparam logic CLIENT_WR = 1'b1;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 8;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/edge_mem_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin choice between the read client (0) and the write
// client (1). The choice is combinational; the last-grant register only moves
// when the owner accepts the grant.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (last grant -> client 1)
//   req0     : client 0 request
//   req1     : client 1 request
//   advance  : owner takes the current grant this cycle
//   any_req  : at least one client is requesting
//   gnt      : winning client index (meaningful only when any_req)
// -----------------------------------------------------------------------------
module rr_arbiter2
    import edge_mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic any_req,
    output logic gnt
);

    logic last_gnt;

    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            // Contention: the client that did not win last time goes first.
            gnt = ~last_gnt;
        end else if (req1) begin
            gnt = CLIENT_WR;
        end else begin
            gnt = CLIENT_RD;
        end
    end

    // Resetting to client 1 makes client 0 win the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= CLIENT_WR;
        end else if (advance && any_req) begin
            last_gnt <= gnt;
        end
    end

endmodule

// File: rtl/edge_mem_scheduler.sv
// -----------------------------------------------------------------------------
// edge_mem_scheduler
// Shares a single waitrequest-style memory master port between the window
// fetch reader (client 0) and the magnitude writeback writer (client 1).
// One transaction at a time: IDLE arbitrates and latches the winner's
// operands, BUSY drives the bus from those latches until waitrequest drops
// (or the watchdog expires), DONE pulses the winner's done for one cycle.
//
// Ports
//   CSI_CLOCK_CLK     : clock, all logic rising-edge
//   CSI_CLOCK_RESET_N : synchronous active-low reset
//   c0_req, c0_addr   : read client request / address
//   c0_done, c0_rdata : read completion pulse / captured data (held)
//   c1_req, c1_addr   : write client request / address
//   c1_wdata          : write client data
//   c1_done           : write completion pulse
//   addressBUS        : master address (latched)
//   writeBUS          : master write data (latched)
//   readEn, WriteEn   : master strobes, never both high
//   readBUS           : master read data
//   waitrequest       : slave stall
//   err               : sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module edge_mem_scheduler
    import edge_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic              CSI_CLOCK_CLK,
    input  logic              CSI_CLOCK_RESET_N,

    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    output logic              c0_done,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_done,

    output logic [ADDR_W-1:0] addressBUS,
    output logic [DATA_W-1:0] writeBUS,
    output logic              readEn,
    output logic              WriteEn,
    input  logic [DATA_W-1:0] readBUS,
    input  logic              waitrequest,

    output logic              err
);

    // Watchdog terminal count: the stall cycle that sees this value aborts.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    state_t                state;
    logic                  own_q;     // latched winner, doubles as direction
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic arb_any;
    logic arb_gnt;
    logic arb_take;

    // Grants are only taken in IDLE, so requests raised during DONE wait for
    // the following IDLE cycle.
    assign arb_take = (state == ST_IDLE);

    rr_arbiter2 u_arb (
        .clk     (CSI_CLOCK_CLK),
        .rst_n   (CSI_CLOCK_RESET_N),
        .req0    (c0_req),
        .req1    (c1_req),
        .advance (arb_take),
        .any_req (arb_any),
        .gnt     (arb_gnt)
    );

    // addressBUS / writeBUS are themselves the operand latches, so the bus
    // never sees client operands that change after the grant.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (!CSI_CLOCK_RESET_N) begin
            state      <= ST_IDLE;
            own_q      <= CLIENT_RD;
            wait_cnt   <= '0;
            addressBUS <= '0;
            writeBUS   <= '0;
            readEn     <= 1'b0;
            WriteEn    <= 1'b0;
            c0_done    <= 1'b0;
            c1_done    <= 1'b0;
            c0_rdata   <= '0;
            err        <= 1'b0;
        end else begin
            // Done strobes are single-cycle by construction.
            c0_done <= 1'b0;
            c1_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        own_q    <= arb_gnt;
                        wait_cnt <= '0;
                        if (arb_gnt == CLIENT_WR) begin
                            addressBUS <= c1_addr;
                            writeBUS   <= c1_wdata;
                            readEn     <= 1'b0;
                            WriteEn    <= 1'b1;
                        end else begin
                            addressBUS <= c0_addr;
                            readEn     <= 1'b1;
                            WriteEn    <= 1'b0;
                        end
                        state <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (!waitrequest || (wait_cnt == WAIT_LAST)) begin
                        // Normal completion or watchdog abort share the exit;
                        // read data is only captured on a real completion.
                        if (!waitrequest) begin
                            if (own_q == CLIENT_RD) begin
                                c0_rdata <= readBUS;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                        readEn  <= 1'b0;
                        WriteEn <= 1'b0;
                        c0_done <= (own_q == CLIENT_RD);
                        c1_done <= (own_q == CLIENT_WR);
                        state   <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    readEn  <= 1'b0;
                    WriteEn <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
